// File: rtl/ps2_scan_text.sv
// PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame decode, ASCII hex line for a UART sender.
// Pulses land one cycle after the stop bit is sampled; no backpressure, a new frame overwrites debug_text.
module ps2_scan_text #(
  parameter int timeout_cycles = 100000,
  parameter int filter_len     = 8,
  parameter int text_len       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [7:0]            scancode,
  output logic                  scan_valid,
  output logic                  frame_err,
  output logic                  text_req,
  output logic [8*text_len-1:0] debug_text
);
  localparam int          TW     = 8 * text_len;
  localparam int          FW     = $clog2(filter_len + 1);
  localparam logic [16:0] TO_LIM = 17'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state;
  logic        clk_m, clk_s, dat_m, dat_s;
  logic        filt, filt_d;
  logic [FW-1:0] fcnt;
  logic [3:0]  bitcnt;
  logic [9:0]  shreg;
  logic [16:0] idle_cnt;
  logic        fall;
  logic [9:0]  nxt;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign fall = filt_d & ~filt;
  assign nxt  = {dat_s, shreg[9:1]};

  // Synchronisers and ps2_clk level filter; filt only follows after filter_len stable cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      dat_m  <= 1'b1;
      dat_s  <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_m  <= ps2_clk;
      clk_s  <= clk_m;
      dat_m  <= ps2_data;
      dat_s  <= dat_m;
      filt_d <= filt;
      if (clk_s != filt) begin
        if (fcnt == FW'(filter_len - 1)) begin
          filt <= clk_s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      scancode   <= 8'h00;
      debug_text <= TW'(32'h3030_0D0A);
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      text_req   <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      text_req   <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall && !dat_s) begin
            state  <= RECV;
            bitcnt <= 4'd1;
            shreg  <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shreg    <= nxt;
            bitcnt   <= bitcnt + 4'd1;
            idle_cnt <= '0;
            // Last bit: decide now so the pulses are visible during DONE.
            if (bitcnt == 4'd10) begin
              state    <= DONE;
              text_req <= 1'b1;
              if ((^nxt[8:0]) && nxt[9]) begin
                scancode   <= nxt[7:0];
                debug_text <= TW'({hex(nxt[7:4]), hex(nxt[3:0]), 8'h0D, 8'h0A});
                scan_valid <= 1'b1;
              end else begin
                debug_text <= TW'(32'h4552_0D0A);
                frame_err  <= 1'b1;
              end
            end
          end else if (idle_cnt == TO_LIM) begin
            state    <= IDLE;
            bitcnt   <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 17'd1;
          end
        end
        default: begin
          state  <= IDLE;
          bitcnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_scan_text.sv
// Directed bench for ps2_scan_text: good/bad frames, timeout, glitch, mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_scan_text;
  localparam int TO   = 300;
  localparam int FL   = 8;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  scancode;
  logic        scan_valid, frame_err, text_req;
  logic [31:0] debug_text;

  int checks = 0;
  int errors = 0;
  int n_sv = 0, n_fe = 0, n_tr = 0;
  int b_sv, b_fe, b_tr;

  ps2_scan_text #(.timeout_cycles(TO), .filter_len(FL), .text_len(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scancode(scancode), .scan_valid(scan_valid), .frame_err(frame_err),
    .text_req(text_req), .debug_text(debug_text)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) n_sv <= n_sv + 1;
    if (frame_err)  n_fe <= n_fe + 1;
    if (text_req)   n_tr <= n_tr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Sends bits [0..nbits-1]; optional low glitch of FL-1 cycles in the high phase after bit glitch_at.
  task automatic send(input logic [10:0] f, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(HALF / 2);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        cyc(5);
        ps2_clk = 1'b0;
        cyc(FL - 1);
        ps2_clk = 1'b1;
        cyc(HALF - 5 - (FL - 1));
      end else begin
        cyc(HALF / 2);
      end
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic mark;
    b_sv = n_sv; b_fe = n_fe; b_tr = n_tr;
  endtask

  task automatic pulses(input string tag, input int sv, input int fe, input int tr);
    check({tag, "_sv"}, 32'(n_sv - b_sv), 32'(sv));
    check({tag, "_fe"}, 32'(n_fe - b_fe), 32'(fe));
    check({tag, "_tr"}, 32'(n_tr - b_tr), 32'(tr));
  endtask

  initial begin
    cyc(3);
    check("rst_scan", {24'h0, scancode}, 32'h0000_0000);
    check("rst_text", debug_text, 32'h3030_0D0A);
    check("rst_pulses", {29'h0, scan_valid, frame_err, text_req}, 32'h0);
    reset = 1'b0;
    cyc(5);

    // Good 0x1C, parity 0
    mark();
    send(frame(8'h1C, 1'b0, 1'b1), 11, -1);
    pulses("good1c", 1, 0, 1);
    check("good1c_scan", {24'h0, scancode}, 32'h1C);
    check("good1c_text", debug_text, 32'h3143_0D0A);

    // Parity error
    mark();
    send(frame(8'h1C, 1'b1, 1'b1), 11, -1);
    pulses("par", 0, 1, 1);
    check("par_scan", {24'h0, scancode}, 32'h1C);
    check("par_text", debug_text, 32'h4552_0D0A);

    // Timeout after 5 bits, then good 0xF0
    mark();
    send(frame(8'h3C, 1'b1, 1'b1), 5, -1);
    cyc(TO + 10);
    pulses("tmo", 0, 0, 0);
    check("tmo_text", debug_text, 32'h4552_0D0A);
    mark();
    send(frame(8'hF0, 1'b1, 1'b1), 11, -1);
    pulses("f0", 1, 0, 1);
    check("f0_scan", {24'h0, scancode}, 32'hF0);
    check("f0_text", debug_text, 32'h4630_0D0A);

    // Glitch inside the frame
    mark();
    send(frame(8'hA5, 1'b1, 1'b1), 11, 4);
    pulses("glitch", 1, 0, 1);
    check("glitch_scan", {24'h0, scancode}, 32'hA5);
    check("glitch_text", debug_text, 32'h4135_0D0A);

    // Reset mid-frame
    send(frame(8'h55, 1'b1, 1'b1), 6, -1);
    reset = 1'b1;
    #1;
    check("mrst_scan", {24'h0, scancode}, 32'h0);
    check("mrst_text", debug_text, 32'h3030_0D0A);
    cyc(3);
    reset = 1'b0;
    cyc(5);
    mark();
    send(frame(8'h00, 1'b1, 1'b1), 11, -1);
    pulses("z00", 1, 0, 1);
    check("z00_text", debug_text, 32'h3030_0D0A);

    // Stop-bit error
    mark();
    send(frame(8'h12, 1'b1, 1'b0), 11, -1);
    pulses("stop", 0, 1, 1);
    check("stop_scan", {24'h0, scancode}, 32'h00);
    check("stop_text", debug_text, 32'h4552_0D0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
